// File: rtl/sng_pkg.sv
// Shared constants and next-state helper for the
// stochastic number generator and its de Bruijn source.
package sng_pkg;

  localparam int W_MIN = 3;
  localparam int W_MAX = 8;

  function automatic logic [7:0] tap_mask(input int width);
    logic [7:0] m;
    case (width)
      3: m = 8'h06;
      4: m = 8'h0C;
      5: m = 8'h14;
      6: m = 8'h30;
      7: m = 8'h60;
      8: m = 8'hB8;
      default: m = 8'h0C;
    endcase
    return m;
  endfunction

  function automatic logic [7:0] debruijn_next(
    input logic [7:0] r,
    input int         width
  );
    logic [7:0] all_m;
    logic [7:0] low_m;
    logic       fb;
    all_m = 8'((16'd1 << width) - 16'd1);
    low_m = all_m >> 1;
    // zero insertion splices state 0 into the m-sequence
    fb = (^(r & tap_mask(width)))
       ^ ((r & low_m) == 8'd0);
    return ((r << 1) | {7'd0, fb}) & all_m;
  endfunction

endpackage

// File: rtl/sng_debruijn_lfsr.sv
// Zero-inserted Fibonacci LFSR: walks all 2^WIDTH
// states once per period, reloadable to a seed.
module sng_debruijn_lfsr #(
  parameter int WIDTH = 4,
  parameter int SEED  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] state
);
  import sng_pkg::*;

  logic [WIDTH-1:0] nxt;

  assign nxt = WIDTH'(debruijn_next(8'(state), WIDTH));

  // load beats advance; hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WIDTH'(SEED);
    end else if (load) begin
      state <= seed;
    end else if (en) begin
      state <= nxt;
    end
  end

endmodule

// File: rtl/sng.sv
// Stochastic number generator: unipolar bitstream
// with exactly x ones per 2^WIDTH-bit period.
module sng #(
  parameter int WIDTH = 4,
  parameter int SEED  = 0
) (
  input  logic             i_clk_sng,
  input  logic             i_rst_sng,
  input  logic [WIDTH-1:0] i_x_bn,
  input  logic             i_start_sng,
  input  logic             i_stop_sng,
  output logic             o_sn_bit
);
  import sng_pkg::*;

  localparam logic [WIDTH-1:0] SEED_V = WIDTH'(SEED);

  logic             active;
  logic [WIDTH-1:0] x_reg;
  logic [WIDTH-1:0] r;
  logic             load;

  // start and stop both rewind the source to SEED
  assign load = i_start_sng | i_stop_sng;

  sng_debruijn_lfsr #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_lfsr (
    .clk   (i_clk_sng),
    .rst_n (i_rst_sng),
    .load  (load),
    .en    (active),
    .seed  (SEED_V),
    .state (r)
  );

  // run control: start wins over stop
  always_ff @(posedge i_clk_sng or negedge i_rst_sng) begin
    if (!i_rst_sng) begin
      active <= 1'b0;
      x_reg  <= '0;
    end else if (i_start_sng) begin
      active <= 1'b1;
      x_reg  <= i_x_bn;
    end else if (i_stop_sng) begin
      active <= 1'b0;
    end
  end

  assign o_sn_bit = active & (x_reg > r);

endmodule

// File: tb/tb_sng.sv
// Self-checking bench for sng (WIDTH=4, SEED=0):
// vector table, hand sequences, random run vs model.
module tb_sng;

  logic       clk;
  logic       rst_n;
  logic [3:0] xin;
  logic       start;
  logic       stop;
  logic       o;

  int checks = 0;
  int errors = 0;

  // reference: the published period-16 source order
  int seq [16] = '{0, 1, 2, 4, 9, 3, 6, 13,
                   10, 5, 11, 7, 15, 14, 12, 8};

  bit m_act;
  int m_x;
  int m_idx;

  typedef struct {
    logic [3:0]  x;
    logic [15:0] exp;
  } vec_t;

  vec_t vt [5];

  sng #(.WIDTH(4), .SEED(0)) dut (
    .i_clk_sng   (clk),
    .i_rst_sng   (rst_n),
    .i_x_bn      (xin),
    .i_start_sng (start),
    .i_stop_sng  (stop),
    .o_sn_bit    (o)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic model_bit();
    return m_act && (m_x > seq[m_idx]);
  endfunction

  task automatic model_edge();
    if (start) begin
      m_act = 1; m_x = int'(xin); m_idx = 0;
    end else if (stop) begin
      m_act = 0; m_idx = 0;
    end else if (m_act) begin
      m_idx = (m_idx + 1) % 16;
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_x = 0; m_idx = 0;
  endtask

  // called at a negedge; returns at the next negedge
  task automatic cyc(input logic s, input logic p,
                     input logic [3:0] x,
                     input string nm);
    start = s; stop = p; xin = x;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check(nm, {31'd0, o}, {31'd0, model_bit()});
  endtask

  task automatic run(input logic [3:0] x, input int n,
                     output logic [31:0] bits);
    bits = '0;
    cyc(1, 1, x, "stream_start");
    bits[0] = o;
    for (int i = 1; i < n; i++) begin
      cyc(0, 0, x, "stream_bit");
      bits[i] = o;
    end
  endtask

  logic [31:0] b;
  int pc;

  initial begin
    vt[0] = '{x: 4'd5,  exp: 16'h002F};
    vt[1] = '{x: 4'd0,  exp: 16'h0000};
    vt[2] = '{x: 4'd15, exp: 16'hEFFF};
    vt[3] = '{x: 4'd9,  exp: 16'h8A6F};
    vt[4] = '{x: 4'd12, exp: 16'h8F7F};

    model_reset();
    rst_n = 0; start = 0; stop = 0; xin = 0;
    repeat (2) @(negedge clk);
    check("reset_out", {31'd0, o}, 32'd0);
    rst_n = 1;
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 4'd7, "idle_out");

    // table vectors: full period per x
    foreach (vt[k]) begin
      run(vt[k].x, 16, b);
      check($sformatf("vec_x%0d", vt[k].x),
            {16'd0, b[15:0]}, {16'd0, vt[k].exp});
    end

    // sweep: popcount equals x
    for (int x = 0; x < 16; x++) begin
      run(4'(x), 16, b);
      pc = $countones(b[15:0]);
      check($sformatf("pop_x%0d", x), pc, x);
    end

    // period: second 16 bits repeat the first
    run(4'd9, 32, b);
    check("period_x9", {16'd0, b[31:16]},
          {16'd0, b[15:0]});

    // stop at cycle 6, x changes mid-run
    cyc(1, 0, 4'd12, "s12_start");
    for (int i = 1; i < 6; i++)
      cyc(0, 0, 4'(i * 3), "s12_run");
    cyc(0, 1, 4'd1, "s12_stop");
    check("s12_after_stop", {31'd0, o}, 32'd0);
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 4'd15, "s12_idle");

    // async reset mid-stream
    cyc(1, 0, 4'd15, "rst_start");
    cyc(0, 0, 4'd15, "rst_run");
    cyc(0, 0, 4'd15, "rst_run");
    check("rst_pre", {31'd0, o}, 32'd1);
    #2 rst_n = 0;
    model_reset();
    #1 check("rst_async", {31'd0, o}, 32'd0);
    @(negedge clk);
    check("rst_held", {31'd0, o}, 32'd0);
    rst_n = 1;
    cyc(0, 0, 4'd15, "rst_idle");
    b = '0;
    cyc(1, 0, 4'd15, "rst_resume");
    b[0] = o;
    for (int i = 1; i < 16; i++) begin
      cyc(0, 0, 4'd3, "rst_resume");
      b[i] = o;
    end
    check("rst_resume_seq", {16'd0, b[15:0]},
          32'h0000EFFF);

    // random start/stop/x against the model
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom % 16) == 0,
          ($urandom % 12) == 0,
          4'($urandom),
          "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
